mem_port_arbiter: RTL and testbench

- Shares the single synchronous data-SRAM port between the instruction-fetch requester and the MEM-stage load/store requester.
- The MEM-stage requester presents byte enables and lane-aligned write data already produced by the memory select logic.
- The block sequences one access at a time with a fixed memory read latency and returns per-requester completion pulses. The pipeline uses these pulses for stall control.
- It sits between the datapath (fetch and MEM stages) and the data SRAM.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_lat.sv | 36 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store SRAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_lat.sv
// Latency counter: loads on issue, decrements while waiting, saturates at zero.
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load_i,
  input  logic                 dec_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  output logic [LAT_CNT_W-1:0] cnt_o,
  output logic                 zero_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and MEM-stage load/store;
// one access in flight, fixed read latency, per-requester completion pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q;
  owner_e              owner_q;
  logic                store_q;
  logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;
  logic                inst_ok_q, data_ok_q;
  logic                issue_ok, issue_data, issue_inst;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                lat_zero;

  // RESP is an issue slot too, which gives back-to-back accesses.
  assign issue_ok   = (state_q == IDLE) || (state_q == RESP);
  assign issue_data = issue_ok && data_req;
  assign issue_inst = issue_ok && !data_req && inst_req;

  always_comb begin
    mem_en       = 1'b0;
    mem_wen      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (issue_data) begin
      mem_en       = 1'b1;
      mem_wen      = data_wen;
      mem_addr     = data_addr;
      mem_wdata    = data_wdata;
      data_addr_ok = 1'b1;
    end else if (issue_inst) begin
      mem_en       = 1'b1;
      mem_addr     = inst_addr;
      inst_addr_ok = 1'b1;
    end
  end

  mem_lat_counter u_lat (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (issue_data || issue_inst),
    .dec_i      (state_q == WAIT),
    .load_val_i (LAT_CNT_W'(MEM_LAT - 1)),
    .cnt_o      (lat_cnt),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      store_q      <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (issue_data) begin
            owner_q <= OWN_DATA;
            store_q <= |data_wen;
            state_q <= WAIT;
          end else if (issue_inst) begin
            owner_q <= OWN_INST;
            store_q <= 1'b0;
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (lat_zero) begin
            state_q <= RESP;
            if (owner_q == OWN_INST) begin
              inst_rdata_q <= mem_rdata;
              inst_ok_q    <= 1'b1;
            end else begin
              data_ok_q <= 1'b1;
              if (!store_q) begin
                data_rdata_q <= mem_rdata;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT=1 and MEM_LAT=3), each with a behavioural SRAM.
module tb_mem_port_arbiter;

  typedef struct {
    int          k;
    bit          who;   // 0 fetch, 1 load/store
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic load_mem = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   busy_until [2];

  logic        inst_req     [2];
  logic [31:0] inst_addr    [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_req     [2];
  logic [3:0]  data_wen     [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        mem_en       [2];
  logic [3:0]  mem_wen      [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic [31:0] mem_rdata    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] idx(input logic [31:0] a);
    return {a[28], a[22], a[7:2]};
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [4];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req[g]),
      .inst_addr    (inst_addr[g]),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req[g]),
      .data_wen     (data_wen[g]),
      .data_addr    (data_addr[g]),
      .data_wdata   (data_wdata[g]),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .mem_en       (mem_en[g]),
      .mem_wen      (mem_wen[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g])
    );

    assign mem_rdata[g] = pipe[LAT-1];

    always @(posedge clk) begin
      if (load_mem) begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        if (g == 0) begin
          mem[idx(32'h0040_0000)] <= 32'h3C1D_8000;
          mem[idx(32'h0040_0004)] <= 32'h27BD_FFF0;
          mem[idx(32'h1000_0010)] <= 32'hCAFE_0010;
          mem[idx(32'h1000_0000)] <= 32'h1122_3344;
        end else begin
          mem[idx(32'h0000_0000)] <= 32'hA5A5_0000;
          mem[idx(32'h0000_0004)] <= 32'h5A5A_0004;
        end
      end else if (mem_en[g]) begin
        pipe[0] <= mem[idx(mem_addr[g])];
        for (int b = 0; b < 4; b++)
          if (mem_wen[g][b]) mem[idx(mem_addr[g])][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Monitor: WAIT quiet-period checks and scoreboard pops on completion pulses.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc <= busy_until[k])
          chk("quiet during WAIT", {29'b0, inst_addr_ok[k], data_addr_ok[k], mem_en[k]}, 32'h0);
        if (mem_en[k]) busy_until[k] = cyc + lat(k);
        if (inst_data_ok[k] || data_data_ok[k]) begin
          if (sb.size() == 0) begin
            chk("unexpected data_ok", {30'b0, inst_data_ok[k], data_data_ok[k]}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk("resp instance", k, e.k);
            chk("resp owner", {30'b0, inst_data_ok[k], data_data_ok[k]}, e.who ? 32'h1 : 32'h2);
            chk("resp cycle", cyc, e.cyc);
            chk("resp rdata", e.who ? data_rdata[k] : inst_rdata[k], e.data);
          end
        end
      end
    end
  end

  task automatic do_inst(input int k, input logic [31:0] addr, input bit expect_rsp,
                         input logic [31:0] exp_data, output int t_acc);
    inst_req[k]  = 1'b1;
    inst_addr[k] = addr;
    t_acc = -1;
    for (int n = 0; n < 50 && t_acc < 0; n++) begin
      @(negedge clk);
      if (inst_addr_ok[k]) begin
        t_acc = cyc;
        chk("inst issue mem_en", mem_en[k], 1);
        chk("inst issue mem_wen", mem_wen[k], 0);
        chk("inst issue mem_addr", mem_addr[k], addr);
        if (expect_rsp) sb.push_back('{k, 1'b0, exp_data, cyc + lat(k) + 1});
      end
      @(posedge clk);
      #1;
    end
    if (t_acc < 0) chk("inst addr_ok timeout", 0, 1);
    inst_req[k]  = 1'b0;
    inst_addr[k] = '0;
  endtask

  task automatic do_data(input int k, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data, output int t_acc);
    data_req[k]   = 1'b1;
    data_wen[k]   = wen;
    data_addr[k]  = addr;
    data_wdata[k] = wdata;
    t_acc = -1;
    for (int n = 0; n < 50 && t_acc < 0; n++) begin
      @(negedge clk);
      if (data_addr_ok[k]) begin
        t_acc = cyc;
        chk("data issue mem_en", mem_en[k], 1);
        chk("data issue mem_wen", mem_wen[k], wen);
        chk("data issue mem_addr", mem_addr[k], addr);
        chk("data issue mem_wdata", mem_wdata[k], wdata);
        if (inst_req[k]) chk("inst_addr_ok while data wins", inst_addr_ok[k], 0);
        sb.push_back('{k, 1'b1, exp_data, cyc + lat(k) + 1});
      end
      @(posedge clk);
      #1;
    end
    if (t_acc < 0) chk("data addr_ok timeout", 0, 1);
    data_req[k]   = 1'b0;
    data_wen[k]   = '0;
    data_addr[k]  = '0;
    data_wdata[k] = '0;
  endtask

  initial begin
    int t1, t2, rel;
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b0; inst_addr[k] = '0;
      data_req[k] = 1'b0; data_wen[k] = '0; data_addr[k] = '0; data_wdata[k] = '0;
      busy_until[k] = -1;
    end
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset inst_rdata", inst_rdata[k], 0);
      chk("reset data_rdata", data_rdata[k], 0);
      chk("reset data_ok", {30'b0, inst_data_ok[k], data_data_ok[k]}, 0);
      chk("reset mem_en", mem_en[k], 0);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // MEM_LAT=1 instance
    do_inst(0, 32'h0040_0000, 1'b1, 32'h3C1D_8000, t1);
    repeat (3) @(posedge clk);
    #1;
    fork
      do_data(0, 4'b0000, 32'h1000_0010, 32'h0, 32'hCAFE_0010, t1);
      do_inst(0, 32'h0040_0004, 1'b1, 32'h27BD_FFF0, t2);
    join
    chk("fetch issued in data RESP", t2, t1 + 2);
    repeat (3) @(posedge clk);
    #1;
    do_data(0, 4'b0100, 32'h1000_0002, 32'h00AB_0000, 32'hCAFE_0010, t1);
    repeat (3) @(posedge clk);
    #1;
    do_data(0, 4'b0000, 32'h1000_0000, 32'h0, 32'h11AB_3344, t1);
    repeat (3) @(posedge clk);
    #1;

    // MEM_LAT=3 instance, back-to-back reads
    do_data(1, 4'b0000, 32'h0000_0000, 32'h0, 32'hA5A5_0000, t1);
    do_data(1, 4'b0000, 32'h0000_0004, 32'h0, 32'h5A5A_0004, t2);
    chk("second issue in first RESP", t2, t1 + 4);
    repeat (8) @(posedge clk);
    #1;

    // Reset during WAIT of a fetch: the access is dropped
    do_inst(1, 32'h0000_0004, 1'b0, 32'h0, t1);
    resetn = 1'b0;
    #1;
    chk("async reset data_rdata", data_rdata[1], 0);
    chk("async reset inst_data_ok", inst_data_ok[1], 0);
    repeat (4) @(posedge clk);
    #1;
    chk("in reset inst_data_ok", inst_data_ok[1], 0);
    chk("in reset inst_rdata", inst_rdata[1], 0);
    resetn = 1'b1;
    rel = cyc;
    do_inst(1, 32'h0000_0000, 1'b1, 32'hA5A5_0000, t2);
    chk("accept right after reset", t2, rel);

    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
